// File: rtl/conv_code_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code (G0=111, G1=101).
// The encoder and the Viterbi decoder both use conv_sym so they cannot diverge.
package conv_code_pkg;

   localparam int K         = 3;
   localparam int M         = K - 1;
   localparam int SYM_W     = 2;
   localparam int MAX_FRAME = 62;
   localparam int CNT_W     = $clog2(MAX_FRAME + 3);
   localparam int IDX_W     = $clog2(MAX_FRAME);

   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_EMIT = 2'd1,
      S_DONE = 2'd2
   } enc_state_t;

   // state[1] is the oldest bit; the result is {G0 parity, G1 parity}
   function automatic logic [SYM_W-1:0] conv_sym(input logic [M-1:0] state, input logic b);
      logic [K-1:0] r;
      r = {state, b};
      return {^(r & G0), ^(r & G1)};
   endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Shift register plus parity function of the convolutional code.
// The symbol output is combinational from the current register and bit_in.
module conv_enc_core
   import conv_code_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic             bit_in,
   output logic [SYM_W-1:0] sym
);

   logic [M-1:0] sr_q;
   logic [M-1:0] sr_d;

   // Clear wins over shift so a new frame always starts from state 0
   always_comb begin
      sr_d = sr_q;
      if (clear) begin
         sr_d = '0;
      end else if (en) begin
         sr_d = {sr_q[M-2:0], bit_in};
      end
   end

   // Shift register storage with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign sym = conv_sym(sr_q, bit_in);

endmodule

// File: rtl/conv_frame_encoder.sv
// Frame-based rate-1/2 convolutional encoder: buffers a frame of data bits,
// then emits one coded symbol per bit followed by two zero-tail symbols.
module conv_frame_encoder
   import conv_code_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             in_last,
   output logic             in_ready,
   input  logic [SYM_W-1:0] sym_flip,
   output logic             sym_valid,
   output logic [SYM_W-1:0] sym_out,
   input  logic             sym_ready,
   output logic             sym_last,
   output logic             busy,
   output logic             frame_done
);

   enc_state_t             state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]       frame_len_q, frame_len_d;
   logic [CNT_W-1:0]       emit_idx_q, emit_idx_d;
   logic [MAX_FRAME-1:0]   bit_buf_q, bit_buf_d;
   logic                   sym_valid_q, sym_valid_d;
   logic [SYM_W-1:0]       sym_out_q, sym_out_d;
   logic                   sym_last_q, sym_last_d;

   logic                   core_clear;
   logic                   core_en;
   logic                   cur_bit;
   logic [SYM_W-1:0]       core_sym;
   logic [CNT_W-1:0]       last_idx;
   logic                   sym_fire;
   logic                   sym_load;

   assign last_idx = frame_len_q + CNT_W'(1);
   assign cur_bit  = (emit_idx_q < frame_len_q) ? bit_buf_q[emit_idx_q[IDX_W-1:0]] : 1'b0;
   assign sym_fire = sym_valid_q && sym_ready;
   assign sym_load = (state_q == S_EMIT) && (!sym_valid_q || sym_ready) && (emit_idx_q <= last_idx);

   conv_enc_core u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (core_clear),
      .en     (core_en),
      .bit_in (cur_bit),
      .sym    (core_sym)
   );

   // Next-state logic: load bits, emit symbols through the output register, then signal done
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      frame_len_d = frame_len_q;
      emit_idx_d  = emit_idx_q;
      bit_buf_d   = bit_buf_q;
      sym_valid_d = sym_valid_q;
      sym_out_d   = sym_out_q;
      sym_last_d  = sym_last_q;
      core_clear  = 1'b0;
      core_en     = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (in_valid) begin
               bit_buf_d[bit_cnt_q[IDX_W-1:0]] = in_bit;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (in_last || (bit_cnt_q == CNT_W'(MAX_FRAME - 1))) begin
                  frame_len_d = bit_cnt_q + CNT_W'(1);
                  emit_idx_d  = '0;
                  core_clear  = 1'b1;
                  state_d     = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            if (sym_fire) begin
               sym_valid_d = 1'b0;
               if (sym_last_q) begin
                  sym_last_d = 1'b0;
                  state_d    = S_DONE;
               end
            end
            if (sym_load) begin
               sym_out_d   = core_sym ^ sym_flip;
               sym_valid_d = 1'b1;
               sym_last_d  = (emit_idx_q == last_idx);
               emit_idx_d  = emit_idx_q + CNT_W'(1);
               core_en     = 1'b1;
            end
         end
         S_DONE: begin
            bit_cnt_d = '0;
            state_d   = S_LOAD;
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_LOAD;
         bit_cnt_q   <= '0;
         frame_len_q <= '0;
         emit_idx_q  <= '0;
         bit_buf_q   <= '0;
         sym_valid_q <= 1'b0;
         sym_out_q   <= '0;
         sym_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_len_q <= frame_len_d;
         emit_idx_q  <= emit_idx_d;
         bit_buf_q   <= bit_buf_d;
         sym_valid_q <= sym_valid_d;
         sym_out_q   <= sym_out_d;
         sym_last_q  <= sym_last_d;
      end
   end

   assign in_ready   = (state_q == S_LOAD);
   assign busy       = (state_q == S_EMIT);
   assign frame_done = (state_q == S_DONE);
   assign sym_valid  = sym_valid_q;
   assign sym_out    = sym_out_q;
   assign sym_last   = sym_last_q;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Self-checking bench for conv_frame_encoder: a bit-level model of the code
// feeds a scoreboard that is checked on every accepted symbol.
module tb_conv_frame_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [1:0] sym_flip = 2'b00;
   logic       sym_valid;
   logic [1:0] sym_out;
   logic       sym_ready = 1'b1;
   logic       sym_last;
   logic       busy;
   logic       frame_done;

   int         checks = 0;
   int         errors = 0;
   int         accepted = 0;

   logic [2:0] exp_q[$];
   logic [1:0] got_q[$];
   logic       frame_bits[$];
   logic [1:0] frame_flips[$];

   bit         toggle_ready = 1'b0;
   bit         mon_en = 1'b0;
   bit         hold_pending = 1'b0;
   logic [1:0] hold_sym;
   logic       hold_last;

   conv_frame_encoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .sym_flip   (sym_flip),
      .sym_valid  (sym_valid),
      .sym_out    (sym_out),
      .sym_ready  (sym_ready),
      .sym_last   (sym_last),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Global guard so the run always terminates
   initial begin
      #400000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Code model: symbol bit1 = b ^ prev1 ^ prev2, bit0 = b ^ prev2, plus two zero tail bits
   task automatic modelFrame();
      int n  = frame_bits.size();
      int p1 = 0;
      int p2 = 0;
      for (int i = 0; i < n + 2; i++) begin
         int         b;
         logic [1:0] s;
         b = (i < n) ? int'(frame_bits[i]) : 0;
         s = {1'(b ^ p1 ^ p2), 1'(b ^ p2)};
         if (i < frame_flips.size()) s = s ^ frame_flips[i];
         exp_q.push_back({s, (i == n + 1)});
         p2 = p1;
         p1 = b;
      end
   endtask

   function automatic int packGot();
      int p = 0;
      foreach (got_q[i]) p = (p << 2) | int'(got_q[i]);
      return p;
   endfunction

   // Drives sym_ready: held high, or toggled every cycle for stall testing
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (toggle_ready) sym_ready = ~sym_ready;
         else              sym_ready = 1'b1;
      end
   end

   // Compare process: every accepted symbol is checked against the model, stalls must hold
   initial begin
      logic [2:0] e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (hold_pending) begin
               checkOutput("stall_hold_valid", int'(sym_valid), 1);
               checkOutput("stall_hold_sym", int'(sym_out), int'(hold_sym));
               checkOutput("stall_hold_last", int'(sym_last), int'(hold_last));
            end
            hold_pending = sym_valid && !sym_ready;
            hold_sym     = sym_out;
            hold_last    = sym_last;
            if (sym_valid && sym_ready) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_symbol", int'(sym_out), -1);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("sym_out", int'(sym_out), int'(e[2:1]));
                  checkOutput("sym_last", int'(sym_last), int'(e[0]));
               end
               got_q.push_back(sym_out);
               accepted++;
            end
         end
      end
   end

   task automatic applyStimulus(input bit use_last);
      int n = frame_bits.size();
      for (int i = 0; i < n; i++) begin
         int t = 0;
         in_valid = 1'b1;
         in_bit   = frame_bits[i];
         in_last  = use_last && (i == n - 1);
         while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
         end
         if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
      in_last  = 1'b0;
      checkOutput("in_ready_drop", int'(in_ready), 0);
      checkOutput("busy_emit", int'(busy), 1);
   endtask

   task automatic waitDone();
      int t = 0;
      @(negedge clk);
      while (!frame_done && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!frame_done) begin
         checkOutput("frame_done_timeout", 0, 1);
      end else begin
         checkOutput("done_sym_valid", int'(sym_valid), 0);
         checkOutput("done_in_ready", int'(in_ready), 0);
         checkOutput("done_busy", int'(busy), 0);
         checkOutput("scoreboard_empty", exp_q.size(), 0);
         @(negedge clk);
         checkOutput("done_one_cycle", int'(frame_done), 0);
         checkOutput("ready_after_done", int'(in_ready), 1);
      end
   endtask

   task automatic newFrame(input int n, input int value);
      frame_bits.delete();
      frame_flips.delete();
      got_q.delete();
      for (int i = 0; i < n; i++) frame_bits.push_back(value[i]);
   endtask

   initial begin
      int t;
      int base;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", int'(in_ready), 1);
      checkOutput("reset_sym_valid", int'(sym_valid), 0);
      checkOutput("reset_sym_out", int'(sym_out), 0);
      checkOutput("reset_sym_last", int'(sym_last), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_frame_done", int'(frame_done), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      $display("[TB] frame 1,0,1,1 with sym_ready high");
      newFrame(4, 4'b1101);
      modelFrame();
      applyStimulus(1'b1);
      waitDone();
      checkOutput("lit_frame_1011", packGot(), 'b11_10_00_01_01_11);

      $display("[TB] single-bit frame 0");
      newFrame(1, 0);
      modelFrame();
      applyStimulus(1'b1);
      waitDone();
      checkOutput("lit_frame_0", packGot(), 'b00_00_00);
      checkOutput("lit_frame_0_count", got_q.size(), 3);

      $display("[TB] 62 ones without in_last");
      frame_bits.delete();
      frame_flips.delete();
      got_q.delete();
      for (int i = 0; i < 62; i++) frame_bits.push_back(1'b1);
      modelFrame();
      applyStimulus(1'b0);
      waitDone();
      checkOutput("max_count", got_q.size(), 64);
      if (got_q.size() == 64) begin
         checkOutput("max_sym0", int'(got_q[0]), 'b11);
         checkOutput("max_sym1", int'(got_q[1]), 'b01);
         checkOutput("max_sym2", int'(got_q[2]), 'b10);
         checkOutput("max_sym30", int'(got_q[30]), 'b10);
         checkOutput("max_sym62", int'(got_q[62]), 'b01);
         checkOutput("max_sym63", int'(got_q[63]), 'b11);
      end

      $display("[TB] frame 1,0,1,1 with sym_ready toggling");
      newFrame(4, 4'b1101);
      modelFrame();
      toggle_ready = 1'b1;
      applyStimulus(1'b1);
      waitDone();
      toggle_ready = 1'b0;
      checkOutput("lit_stall_1011", packGot(), 'b11_10_00_01_01_11);
      checkOutput("lit_stall_count", got_q.size(), 6);

      $display("[TB] frame 1,0,1,1 with flip on second symbol");
      newFrame(4, 4'b1101);
      frame_flips.push_back(2'b00);
      frame_flips.push_back(2'b01);
      modelFrame();
      applyStimulus(1'b1);
      t = 0;
      while (!sym_valid && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!sym_valid) checkOutput("flip_first_valid_timeout", 0, 1);
      sym_flip = 2'b01;
      @(posedge clk);
      #1;
      sym_flip = 2'b00;
      waitDone();
      checkOutput("lit_flip_1011", packGot(), 'b11_11_00_01_01_11);

      $display("[TB] reset after third symbol");
      newFrame(4, 4'b1101);
      modelFrame();
      base = accepted;
      applyStimulus(1'b1);
      t = 0;
      while ((accepted - base) < 3 && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      if ((accepted - base) < 3) checkOutput("reset_wait_timeout", 0, 1);
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midreset_sym_valid", int'(sym_valid), 0);
      checkOutput("midreset_in_ready", int'(in_ready), 1);
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_sym_last", int'(sym_last), 0);
      rst_n = 1'b1;
      exp_q.delete();
      hold_pending = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      newFrame(1, 1);
      modelFrame();
      applyStimulus(1'b1);
      waitDone();
      checkOutput("lit_after_reset", packGot(), 'b11_10_11);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
